// File: rtl/tt_pin_bist.sv
// Pin-level BIST engine: sweeps all 256 input vectors into a combinational user design,
// checks the low response nibble against a NAND golden model and compacts responses in a MISR.
module tt_pin_bist #(
    parameter int          SETTLE    = 2,
    parameter logic [3:0]  CMP_MASK  = 4'hF,
    parameter logic [15:0] MISR_POLY = 16'h8016,
    parameter logic [15:0] SIG_SEED  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    output logic [7:0]  stim_out,
    input  logic [7:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  mism_cnt,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state;
    logic [3:0]  settle_cnt;
    logic        miss;
    logic [7:0]  mism_nxt;
    logic [15:0] sig_nxt;

    function automatic logic nand_miss(input logic [7:0] stim, input logic [7:0] resp);
        logic [3:0] golden;
        golden = ~(stim[3:0] & stim[7:4]);
        return |((resp[3:0] ^ golden) & CMP_MASK);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic hit);
        if (hit && cnt != 8'hFF)
            return cnt + 8'd1;
        return cnt;
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [7:0] data);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {8'h00, data};
    endfunction

    always_comb begin
        miss     = nand_miss(stim_out, resp_in);
        mism_nxt = sat_inc(mism_cnt, miss);
        sig_nxt  = misr_step(signature, resp_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stim_out   <= 8'h00;
            settle_cnt <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            mism_cnt   <= 8'h00;
            signature  <= SIG_SEED;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    // A restart from DONE is identical to a fresh start from IDLE.
                    if (start) begin
                        state      <= DRIVE;
                        stim_out   <= 8'h00;
                        settle_cnt <= 4'd0;
                        mism_cnt   <= 8'h00;
                        signature  <= SIG_SEED;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    mism_cnt  <= mism_nxt;
                    signature <= sig_nxt;
                    if (stim_out == 8'hFF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mism_nxt == 8'h00);
                    end else begin
                        state      <= DRIVE;
                        stim_out   <= stim_out + 8'd1;
                        settle_cnt <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_pin_bist.sv
// Scoreboard bench for tt_pin_bist: the driver queues expected run results, a monitor checks them on done.
module tb_tt_pin_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        start;
    int          fault;

    logic [7:0]  stim_a, resp_a, mism_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] sig_a;

    logic [7:0]  stim_b, resp_b, mism_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          done_cyc;
        int          lat;
        logic [7:0]  mism_a;
        logic [7:0]  mism_b;
        logic [15:0] sig;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_pin_bist u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .stim_out(stim_a), .resp_in(resp_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mism_cnt(mism_a), .signature(sig_a)
    );

    tt_pin_bist #(.CMP_MASK(4'hE)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .stim_out(stim_b), .resp_in(resp_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mism_cnt(mism_b), .signature(sig_b)
    );

    // fault 0: ideal NAND DUT, 1: bit0 stuck at 0, 2: bit3 stuck at 1
    function automatic logic [7:0] dut_model(input logic [7:0] s, input int f);
        logic [7:0] r;
        r = {4'h0, ~(s[3:0] & s[7:4])};
        if (f == 1) r[0] = 1'b0;
        if (f == 2) r[3] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] misr_ref(input int f);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int v = 0; v < 256; v++)
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h8016 : 16'h0000) ^ {8'h00, dut_model(8'(v), f)};
        return s;
    endfunction

    always_comb resp_a = dut_model(stim_a, fault);
    always_comb resp_b = dut_model(stim_b, fault);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation on every rising edge of done.
    logic done_prev = 1'b0;
    int   busy_cnt  = 0;
    always @(negedge clk) begin
        if (done_a && !done_prev) begin
            check("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_len", 32'(busy_cnt), 32'(e.lat));
                check("stim_final", 32'(stim_a), 32'hFF);
                check("mism_cnt", 32'(mism_a), 32'(e.mism_a));
                check("pass", 32'(pass_a), 32'(e.mism_a == 8'h00));
                check("signature", 32'(sig_a), 32'(e.sig));
                check("m_done", 32'(done_b), 32'd1);
                check("m_mism_cnt", 32'(mism_b), 32'(e.mism_b));
                check("m_pass", 32'(pass_b), 32'(e.mism_b == 8'h00));
                check("m_signature", 32'(sig_b), 32'(e.sig));
            end
        end
        if (busy_a) busy_cnt <= busy_cnt + 1;
        else        busy_cnt <= 0;
        done_prev <= done_a;
    end

    task automatic start_run(input int f, input int lat, input bit push);
        exp_t e;
        logic [7:0] tbl_a [3];
        logic [7:0] tbl_b [3];
        tbl_a = '{8'd0, 8'd192, 8'd64};
        tbl_b = '{8'd0, 8'd0, 8'd64};
        fault = f;
        @(negedge clk);
        start = 1'b1;
        if (push) begin
            e.done_cyc = cyc + 1 + lat;
            e.lat      = lat;
            e.mism_a   = tbl_a[f];
            e.mism_b   = tbl_b[f];
            e.sig      = misr_ref(f);
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_done", 32'(done_a), 32'd0);
        check("start_pass", 32'(pass_a), 32'd0);
        check("start_stim", 32'(stim_a), 32'd0);
        check("start_mism", 32'(mism_a), 32'd0);
        check("start_sig", 32'(sig_a), 32'hFFFF);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done_a && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done_a), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stim"}, 32'(stim_a), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
        check({tag, "_mism"}, 32'(mism_a), 32'd0);
        check({tag, "_sig"}, 32'(sig_a), 32'hFFFF);
        check({tag, "_m_busy"}, 32'(busy_b), 32'd0);
    endtask

    logic [15:0] sig_ideal;
    logic [7:0]  frozen_stim;

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        fault = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // Ideal DUT
        start_run(0, 768, 1);
        wait_done(900);
        sig_ideal = sig_a;

        // Stuck-at faults
        start_run(1, 768, 1);
        wait_done(900);
        check("sig_differs", 32'(sig_a != sig_ideal), 32'd1);
        start_run(2, 768, 1);
        wait_done(900);

        // start while busy must be ignored
        start_run(0, 768, 1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(900);
        repeat (5) @(negedge clk);
        check("done_held", 32'(done_a), 32'd1);
        start_run(0, 768, 1);
        wait_done(900);
        check("rerun_sig_same", 32'(sig_a), 32'(sig_ideal));

        // Asynchronous reset mid-run at vector 0x40
        start_run(0, 768, 0);
        begin
            int n = 0;
            while (stim_a != 8'h40 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("reach_vec40", 32'(stim_a), 32'h40);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(0, 768, 1);
        wait_done(900);

        // ena low freezes everything for 50 cycles
        start_run(0, 818, 1);
        repeat (100) @(negedge clk);
        ena = 1'b0;
        frozen_stim = stim_a;
        repeat (50) @(negedge clk);
        check("ena_stim_frozen", 32'(stim_a), 32'(frozen_stim));
        check("ena_busy_held", 32'(busy_a), 32'd1);
        ena = 1'b1;
        wait_done(950);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
